mem_port_arbiter: RTL and testbench

//   Shares one single-port, fixed-latency memory between the fetch stage and the

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between instruction fetch
// and the load/store stage; data wins by default, a starvation counter forces fetch.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;    // 1 = data port owns the access in flight
  logic        own_we_q, own_we_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_f, grant_d, force_f;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    owner_d   = owner_q;
    own_we_d  = own_we_q;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    force_f   = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = 32'd0;
    m_wdata   = 32'd0;
    m_size    = 2'd0;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        // Arbitration is gated by reset so every output reads 0 while it is held.
        if (reset) begin
          force_f = f_req && (int'(starve_q) == STARVE_LIMIT);
          if (d_req && !force_f) grant_d = 1'b1;
          else if (f_req)        grant_f = 1'b1;
        end
        if (grant_d) begin
          state_d  = S_WAIT;
          lat_d    = LAT_INIT;
          owner_d  = 1'b1;
          own_we_d = d_we;
          starve_d = f_req ? sat_inc(starve_q) : 4'd0;
          m_en     = 1'b1;
          m_we     = d_we;
          m_addr   = d_addr;
          m_wdata  = d_wdata;
          m_size   = d_size;
        end else if (grant_f) begin
          state_d  = S_WAIT;
          lat_d    = LAT_INIT;
          owner_d  = 1'b0;
          own_we_d = 1'b0;
          starve_d = 4'd0;
          m_en     = 1'b1;
          m_addr   = f_addr;
          m_size   = 2'd2;
        end
      end
      S_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = S_RESP;
          if (owner_q) d_rdata_d = own_we_q ? 32'd0 : m_rdata;
          else         f_rdata_d = m_rdata;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lat_q     <= 4'd0;
      starve_q  <= 4'd0;
      owner_q   <= 1'b0;
      own_we_q  <= 1'b0;
      f_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      owner_q   <= owner_d;
      own_we_q  <= own_we_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign f_gnt    = grant_f;
  assign d_gnt    = grant_d;
  assign f_rvalid = (state_q == S_RESP) && !owner_q;
  assign d_done   = (state_q == S_RESP) && owner_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand sequences, responses checked
// against a scoreboard queue fed by a latency-accurate memory model.
module tb_mem_port_arbiter;

  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int SL = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b0;

  logic        f_req, f_gnt, f_rvalid, d_req, d_we, d_gnt, d_done, m_en, m_we, busy;
  logic [31:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [1:0]  d_size, m_size;

  logic        b_f_req, b_f_gnt, b_f_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_done, b_m_en, b_m_we, b_busy;
  logic [31:0] b_f_addr, b_f_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;
  logic [1:0]  b_d_size, b_m_size;

  mem_port_arbiter #(.MEM_LATENCY(L0), .STARVE_LIMIT(SL)) u_dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(L1), .STARVE_LIMIT(SL)) u_dut1 (
    .clock(clock), .reset(reset),
    .f_req(b_f_req), .f_addr(b_f_addr), .f_gnt(b_f_gnt), .f_rvalid(b_f_rvalid), .f_rdata(b_f_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_size(b_d_size),
    .d_gnt(b_d_gnt), .d_done(b_d_done), .d_rdata(b_d_rdata),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_size(b_m_size),
    .m_rdata(b_m_rdata), .busy(b_busy)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          exp_we;
    logic [1:0]  exp_size;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          due;
  } sb_t;

  sb_t  sbq[$];
  sb_t  mon_e;
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0100_0000) return 32'h0050_0093;
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Memory models: read data is valid only in the cycle exactly LATENCY after issue.
  bit          p0_en [L0];
  logic [31:0] p0_addr [L0];
  bit          p1_en [L1];
  logic [31:0] p1_addr [L1];
  always @(posedge clock) begin
    p0_en[0]   <= m_en;
    p0_addr[0] <= m_addr;
    for (int i = 1; i < L0; i++) begin
      p0_en[i]   <= p0_en[i-1];
      p0_addr[i] <= p0_addr[i-1];
    end
    p1_en[0]   <= b_m_en;
    p1_addr[0] <= b_m_addr;
  end
  assign m_rdata   = p0_en[L0-1] ? mem_fn(p0_addr[L0-1]) : 32'hBAD0_BAD0;
  assign b_m_rdata = p1_en[L1-1] ? mem_fn(p1_addr[L1-1]) : 32'hBAD0_BAD0;

  always @(negedge clock) begin
    if (f_rvalid || d_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'({f_rvalid, d_done}), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_cycle", cyc, mon_e.due);
        chk("resp_port", 32'({f_rvalid, d_done}), mon_e.is_d ? 32'd1 : 32'd2);
        chk("resp_data", mon_e.is_d ? d_rdata : f_rdata, mon_e.rdata);
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
      chk("resp_missing", cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
  end

  task automatic do_vec(input vec_t v);
    bit got = 1'b0;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_size = v.size;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clock);
      if (v.is_d ? d_gnt : f_gnt) got = 1'b1;
    end
    if (!got) begin
      chk("grant_timeout", 32'd0, 32'd1);
    end else begin
      chk("other_gnt", 32'(v.is_d ? f_gnt : d_gnt), 32'd0);
      chk("m_en", 32'(m_en), 32'd1);
      chk("m_we", 32'(m_we), 32'(v.exp_we));
      chk("m_addr", m_addr, v.addr);
      chk("m_size", 32'(m_size), 32'(v.exp_size));
      if (v.exp_we) chk("m_wdata", m_wdata, v.wdata);
      sbq.push_back('{v.is_d, v.exp_rdata, cyc + L0 + 1});
    end
    @(posedge clock); #1;
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clock);
    chk("busy_wait", 32'(busy), 32'd1);
    chk("m_en_wait", 32'(m_en), 32'd0);
    repeat (L0 + 1) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    bit exp_f;
    vecs[0] = '{1'b0, 1'b0, 32'h0100_0000, 32'h0, 2'd2, 1'b0, 2'd2, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b0, 32'h0100_0100, 32'h0, 2'd2, 1'b0, 2'd2, mem_fn(32'h0100_0100)};
    vecs[2] = '{1'b1, 1'b1, 32'h0100_0104, 32'hDEAD_BEEF, 2'd2, 1'b1, 2'd2, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0100_0203, 32'h1234_5678, 2'd0, 1'b0, 2'd0, mem_fn(32'h0100_0203)};
    vecs[4] = '{1'b1, 1'b0, 32'h0100_0010, 32'h0, 2'd3, 1'b0, 2'd3, mem_fn(32'h0100_0010)};
    vecs[5] = '{1'b0, 1'b0, 32'h0100_0004, 32'h0, 2'd0, 1'b0, 2'd2, mem_fn(32'h0100_0004)};
    vecs[6] = '{1'b1, 1'b1, 32'h0100_0202, 32'h0000_CAFE, 2'd1, 1'b1, 2'd1, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h7FFF_FFFC, 32'h0, 2'd0, 1'b0, 2'd2, mem_fn(32'h7FFF_FFFC)};

    f_req = 1'b1; f_addr = 32'h0100_0000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0100_0104; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
    b_f_req = 1'b0; b_f_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 32'h0; b_d_wdata = 32'h0; b_d_size = 2'd2;

    // Reset held with both requests raised: every output must stay 0.
    repeat (2) @(negedge clock);
    chk("rst_outs_zero", 32'(|{f_gnt, f_rvalid, f_rdata, d_gnt, d_done, d_rdata, m_en, m_we,
                               m_addr, m_wdata, m_size, busy}), 32'd0);
    chk("rst_outs_zero_b", 32'(|{b_f_gnt, b_f_rvalid, b_f_rdata, b_d_gnt, b_d_done, b_d_rdata,
                                 b_m_en, b_m_we, b_m_addr, b_m_wdata, b_m_size, b_busy}), 32'd0);
    @(posedge clock); #1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) do_vec(vecs[i]);
    chk("f_rdata_hold", f_rdata, mem_fn(32'h7FFF_FFFC));

    // Simultaneous fetch and load: load first, fetch granted in the RESP cycle.
    f_req = 1'b1; f_addr = 32'h0100_0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0100; d_size = 2'd2;
    @(negedge clock);
    chk("t2_d_gnt", 32'(d_gnt), 32'd1);
    chk("t2_f_gnt0", 32'(f_gnt), 32'd0);
    sbq.push_back('{1'b1, mem_fn(32'h0100_0100), cyc + 3});
    @(posedge clock); #1;
    d_req = 1'b0;
    for (int k = 1; k < 3; k++) begin
      @(negedge clock);
      chk("t2_no_gnt_wait", 32'(f_gnt), 32'd0);
    end
    @(negedge clock);
    chk("t2_f_gnt_resp", 32'(f_gnt), 32'd1);
    chk("t2_d_done_resp", 32'(d_done), 32'd1);
    sbq.push_back('{1'b0, mem_fn(32'h0100_0040), cyc + 3});
    @(posedge clock); #1;
    f_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Both held: starvation pattern D,D,D,D,F repeating, one grant per 3 cycles.
    f_req = 1'b1; f_addr = 32'h0100_0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0300; d_size = 2'd2;
    for (int k = 0; k < 28; k++) begin
      @(negedge clock);
      if (k % 3 == 0) begin
        exp_f = ((k / 3) % 5 == 4);
        chk("t4_f_gnt", 32'(f_gnt), 32'(exp_f));
        chk("t4_d_gnt", 32'(d_gnt), 32'(!exp_f));
        sbq.push_back('{!exp_f, exp_f ? mem_fn(32'h0100_0020) : mem_fn(32'h0100_0300), cyc + 3});
      end else begin
        chk("t4_idle_gnt", 32'({f_gnt, d_gnt}), 32'd0);
      end
    end
    @(posedge clock); #1;
    f_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Reset during an in-flight fetch: its response must never appear.
    f_req = 1'b1; f_addr = 32'h0100_0000;
    @(negedge clock);
    chk("t5_f_gnt_c0", 32'(f_gnt), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0; f_addr = 32'h0100_0008;
    @(negedge clock);
    chk("t5_outs_zero", 32'(|{f_gnt, f_rvalid, d_gnt, d_done, d_rdata, m_en, m_we,
                              m_addr, m_wdata, m_size, busy}), 32'd0);
    chk("t5_f_rdata_zero", f_rdata, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("t5_f_gnt_c2", 32'(f_gnt), 32'd1);
    chk("t5_m_addr_c2", m_addr, 32'h0100_0008);
    sbq.push_back('{1'b0, mem_fn(32'h0100_0008), cyc + 3});
    @(posedge clock); #1;
    f_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // MEM_LATENCY=1 instance: back-to-back loads, one access every 2 cycles.
    b_d_req = 1'b1; b_d_addr = 32'h0100_0400;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      chk("t6_d_gnt", 32'(b_d_gnt), 32'(k == 0 || k == 2 || k == 4));
      chk("t6_busy", 32'(b_busy), 32'(k % 2 == 1));
      chk("t6_d_done", 32'(b_d_done), 32'(k == 2 || k == 4 || k == 6));
      if (k == 2 || k == 4 || k == 6)
        chk("t6_d_rdata", b_d_rdata, mem_fn(32'h0100_0400 + 32'(4 * (k / 2 - 1))));
      chk("t6_f_rvalid", 32'(b_f_rvalid), 32'd0);
      @(posedge clock); #1;
      if (k == 0 || k == 2) b_d_addr = b_d_addr + 32'd4;
      if (k == 4) b_d_req = 1'b0;
    end

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
